// File: rtl/sdram_burst_responder.sv
// sdram_burst_responder
//
// Turns a single burst read request into a stream of 16-bit word reads towards
// a memory controller. The returned words are delivered as 16-bit beats, or
// packed in pairs into 32-bit beats. The end of the burst is marked by a
// one-cycle done pulse.
//
// Ports
//   sdram_clk        clock, rising edge
//   nRESET           synchronous active-low reset
//   burst_rd         burst request strobe, only honoured while idle
//   burst_addr       byte start address (bit 0 ignored)
//   burst_len        burst length in 16-bit words (0 = immediate done)
//   burst_32bit      1: pack word pairs into 32-bit beats, 0: one word per beat
//   burst_data       returned beat, held between valids
//   burst_data_valid one cycle per beat
//   burst_data_done  one cycle end-of-burst pulse
//   busy             from the cycle after acceptance through the done cycle
//   mem_rd/mem_addr  word read request, held until mem_ready
//   mem_ready        request handshake
//   mem_rdata(_valid) returned words, in request order
module sdram_burst_responder #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        sdram_clk,
  input  logic        nRESET,
  input  logic        burst_rd,
  input  logic [25:0] burst_addr,
  input  logic [10:0] burst_len,
  input  logic        burst_32bit,
  output logic [31:0] burst_data,
  output logic        burst_data_valid,
  output logic        burst_data_done,
  output logic        busy,
  output logic        mem_rd,
  output logic [24:0] mem_addr,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rdata_valid
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [24:0] base_q, base_d;
  logic [10:0] len_q, len_d;
  logic        mode32_q, mode32_d;
  logic [10:0] issued_q, issued_d;
  logic [10:0] recv_q, recv_d;
  logic [3:0]  outst_q, outst_d;
  logic [15:0] hold_q, hold_d;
  logic        pend_q, pend_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        rd_q, rd_d;
  logic [24:0] addr_q, addr_d;
  logic        accept;
  logic        take;
  logic        unused_addr0;

  assign unused_addr0 = burst_addr[0];

  // rd_q is only ever high in StRun, so no state qualifier is needed here.
  assign accept = rd_q & mem_ready;
  // Returns outside a burst, or beyond the requested length, are dropped.
  assign take   = (state_q == StRun) && mem_rdata_valid && (recv_q != len_q);

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    mode32_d = mode32_q;
    issued_d = issued_q;
    recv_d   = recv_q;
    outst_d  = outst_q;
    hold_d   = hold_q;
    pend_d   = pend_q;
    data_d   = data_q;
    valid_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (burst_rd) begin
          base_d   = burst_addr[25:1];
          len_d    = burst_len;
          mode32_d = burst_32bit;
          issued_d = '0;
          recv_d   = '0;
          outst_d  = '0;
          pend_d   = 1'b0;
          state_d  = (burst_len == 11'd0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (accept) issued_d = issued_q + 11'd1;
        outst_d = outst_q + {3'b0, accept} - {3'b0, take};
        if (take) begin
          recv_d = recv_q + 11'd1;
          if (!mode32_q) begin
            data_d  = {16'h0000, mem_rdata};
            valid_d = 1'b1;
          end else if (pend_q) begin
            data_d  = {hold_q, mem_rdata};
            valid_d = 1'b1;
            pend_d  = 1'b0;
          end else if (recv_d == len_q) begin
            // Odd length: the last word forms a half-filled beat.
            data_d  = {mem_rdata, 16'h0000};
            valid_d = 1'b1;
          end else begin
            hold_d = mem_rdata;
            pend_d = 1'b1;
          end
        end
        // The final beat is the only one emitted once every word has arrived.
        if (valid_q && (recv_q == len_q)) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    done_d = (state_d == StDone);
    busy_d = (state_d != StIdle);
    rd_d   = (state_d == StRun) && (issued_d != len_d) &&
             (outst_d < 4'(MAX_OUTSTANDING));
    // Natural 25-bit overflow gives the required address wrap.
    addr_d = base_d + 25'(issued_d);
  end

  always_ff @(posedge sdram_clk) begin
    if (!nRESET) begin
      state_q  <= StIdle;
      base_q   <= '0;
      len_q    <= '0;
      mode32_q <= 1'b0;
      issued_q <= '0;
      recv_q   <= '0;
      outst_q  <= '0;
      hold_q   <= '0;
      pend_q   <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      mode32_q <= mode32_d;
      issued_q <= issued_d;
      recv_q   <= recv_d;
      outst_q  <= outst_d;
      hold_q   <= hold_d;
      pend_q   <= pend_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
    end
  end

  assign burst_data       = data_q;
  assign burst_data_valid = valid_q;
  assign burst_data_done  = done_q;
  assign busy             = busy_q;
  assign mem_rd           = rd_q;
  assign mem_addr         = addr_q;

endmodule

// File: tb/tb_sdram_burst_responder.sv
// Testbench for sdram_burst_responder: directed table of bursts, random bursts
// against a queue-based memory/beat model, and hand sequences for zero-length
// bursts and reset in the middle of a burst.
module tb_sdram_burst_responder;

  localparam int unsigned MaxOut = 4;

  logic        sdram_clk = 1'b0;
  logic        nRESET = 1'b0;
  logic        burst_rd = 1'b0;
  logic [25:0] burst_addr = '0;
  logic [10:0] burst_len = '0;
  logic        burst_32bit = 1'b0;
  logic [31:0] burst_data;
  logic        burst_data_valid;
  logic        burst_data_done;
  logic        busy;
  logic        mem_rd;
  logic [24:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        mem_rdata_valid = 1'b0;

  always #5 sdram_clk = ~sdram_clk;

  sdram_burst_responder #(.MAX_OUTSTANDING(MaxOut)) dut (
    .sdram_clk        (sdram_clk),
    .nRESET           (nRESET),
    .burst_rd         (burst_rd),
    .burst_addr       (burst_addr),
    .burst_len        (burst_len),
    .burst_32bit      (burst_32bit),
    .burst_data       (burst_data),
    .burst_data_valid (burst_data_valid),
    .burst_data_done  (burst_data_done),
    .busy             (busy),
    .mem_rd           (mem_rd),
    .mem_addr         (mem_addr),
    .mem_ready        (mem_ready),
    .mem_rdata        (mem_rdata),
    .mem_rdata_valid  (mem_rdata_valid)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [25:0] addr;
    int          len;
    bit          m32;
    int          rdy_pct;
    int          lat_min;
    int          lat_max;
    int          word_base;  // 0: random words, else word i = (base+i)*0x1111
    bit          chk_first;
    logic [24:0] exp_addr0;
    logic [31:0] exp_beat0;
    int          exp_beats;
  } vec_t;

  vec_t vecs[5];

  // Runs one burst against a memory model; inputs are applied on negedges,
  // outputs sampled on negedges.
  task automatic run_burst(input vec_t v, input bit inject);
    logic [15:0] words[$];
    logic [31:0] beats[$];
    logic [15:0] ret_word[$];
    int          ret_time[$];
    int          issued = 0;
    int          outst = 0;
    int          cyc = 0;
    int          nbeats = 0;
    int          last_valid = -10;
    bit          done_seen = 1'b0;
    bit          stalled = 1'b0;
    bit          got_addr = 1'b0;
    logic [24:0] stall_addr = '0;
    logic [24:0] base;
    logic [15:0] w;

    base = v.addr[25:1];
    for (int i = 0; i < v.len; i++) begin
      if (v.word_base != 0) w = 16'((v.word_base + i) * 32'h1111);
      else w = 16'($urandom);
      words.push_back(w);
    end
    if (v.m32) begin
      for (int j = 0; j < v.len; j += 2) begin
        if (j + 1 < v.len) beats.push_back({words[j], words[j+1]});
        else beats.push_back({words[j], 16'h0000});
      end
    end else begin
      foreach (words[i]) beats.push_back({16'h0000, words[i]});
    end

    burst_addr  = v.addr;
    burst_len   = 11'(v.len);
    burst_32bit = v.m32;
    burst_rd    = 1'b1;
    @(negedge sdram_clk);
    // Scramble request inputs: the burst must run from latched values.
    burst_rd    = 1'b0;
    burst_addr  = 26'($urandom);
    burst_len   = 11'($urandom);
    burst_32bit = 1'($urandom);

    while (!done_seen && cyc < 3000) begin
      check("busy_during_burst", 32'(busy), 32'd1);
      if (stalled) begin
        check("stall_mem_rd", 32'(mem_rd), 32'd1);
        check("stall_mem_addr", 32'(mem_addr), 32'(stall_addr));
      end
      if (burst_data_valid) begin
        check("beat_expected", 32'(beats.size() != 0), 32'd1);
        if (beats.size() != 0) begin
          if (nbeats == 0 && v.chk_first) check("first_beat", burst_data, v.exp_beat0);
          check("beat_data", burst_data, beats.pop_front());
        end
        nbeats++;
        last_valid = cyc;
      end
      if (burst_data_done) begin
        done_seen = 1'b1;
        if (v.len == 0) check("done_latency_len0", 32'(cyc), 32'd0);
        else check("done_after_last_beat", 32'(cyc - last_valid), 32'd1);
        check("mem_rd_at_done", 32'(mem_rd), 32'd0);
      end

      mem_ready = ($urandom_range(99) < 32'(v.rdy_pct));
      stalled = mem_rd && !mem_ready && !done_seen;
      stall_addr = mem_addr;
      if (mem_rd && mem_ready) begin
        check("mem_addr", 32'(mem_addr), 32'(25'(base + 25'(issued))));
        check("request_within_len", 32'(issued < v.len), 32'd1);
        if (!got_addr && v.chk_first) check("first_mem_addr", 32'(mem_addr), 32'(v.exp_addr0));
        got_addr = 1'b1;
        ret_word.push_back(issued < v.len ? words[issued] : 16'h0000);
        ret_time.push_back(cyc + int'($urandom_range(v.lat_max, v.lat_min)));
        issued++;
        outst++;
        check("outstanding_limit", 32'(outst <= int'(MaxOut)), 32'd1);
      end
      if (ret_time.size() != 0 && ret_time[0] <= cyc) begin
        mem_rdata_valid = 1'b1;
        mem_rdata = ret_word.pop_front();
        void'(ret_time.pop_front());
        outst--;
      end else begin
        mem_rdata_valid = 1'b0;
        mem_rdata = 16'($urandom);
      end
      burst_rd = inject && (cyc == 2) && !done_seen;
      @(negedge sdram_clk);
      cyc++;
    end

    burst_rd = 1'b0;
    mem_ready = 1'b0;
    mem_rdata_valid = 1'b0;
    check("done_seen", 32'(done_seen), 32'd1);
    check("beat_count", 32'(nbeats), 32'(v.exp_beats));
    check("request_count", 32'(issued), 32'(v.len));
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_single_cycle", 32'(burst_data_done), 32'd0);
  endtask

  initial begin
    vec_t rv;
    int   done_cnt;

    //          addr          len m32 rdy lat    base chk  addr0         beat0         beats
    vecs[0] = '{26'h0000100,  4,  1, 100, 2, 2,  1,  1, 25'h0000080, 32'h11112222, 2};
    vecs[1] = '{26'h3FFFFFC,  3,  0, 100, 1, 3,  1,  1, 25'h1FFFFFE, 32'h00001111, 3};
    vecs[2] = '{26'h0001234,  3,  1,  70, 1, 4, 10,  1, 25'h000091A, 32'hAAAABBBB, 2};
    vecs[3] = '{26'h0002000,  8,  0,  40, 12, 20, 1, 1, 25'h0001000, 32'h00001111, 8};
    vecs[4] = '{26'h00000FF,  1,  1, 100, 1, 1,  5,  1, 25'h000007F, 32'h55550000, 1};

    // Reset, with a burst request held during reset that must be ignored.
    nRESET = 1'b0;
    burst_rd = 1'b1;
    burst_len = 11'd5;
    repeat (3) @(negedge sdram_clk);
    check("reset_burst_data", burst_data, 32'h0);
    check("reset_valid", 32'(burst_data_valid), 32'd0);
    check("reset_done", 32'(burst_data_done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_mem_rd", 32'(mem_rd), 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    nRESET = 1'b1;
    burst_rd = 1'b0;
    @(negedge sdram_clk);
    check("rd_during_reset_ignored", 32'(busy), 32'd0);

    foreach (vecs[i]) run_burst(vecs[i], 1'b1);

    // Zero-length burst, with a second request while busy.
    burst_addr = 26'h0000400;
    burst_len = 11'd0;
    burst_32bit = 1'b0;
    burst_rd = 1'b1;
    @(negedge sdram_clk);
    burst_len = 11'd3;
    check("len0_done", 32'(burst_data_done), 32'd1);
    check("len0_busy", 32'(busy), 32'd1);
    check("len0_mem_rd", 32'(mem_rd), 32'd0);
    @(negedge sdram_clk);
    burst_rd = 1'b0;
    check("len0_done_pulse", 32'(burst_data_done), 32'd0);
    check("len0_busy_clear", 32'(busy), 32'd0);
    @(negedge sdram_clk);
    check("len0_second_rd_ignored", 32'(busy), 32'd0);
    check("len0_no_mem_rd", 32'(mem_rd), 32'd0);
    check("len0_no_valid", 32'(burst_data_valid), 32'd0);

    // Reset in the middle of a 16-bit burst.
    burst_addr = 26'h0000400;
    burst_len = 11'd8;
    burst_32bit = 1'b0;
    burst_rd = 1'b1;
    @(negedge sdram_clk);
    burst_rd = 1'b0;
    mem_ready = 1'b1;
    @(negedge sdram_clk);
    mem_ready = 1'b0;
    mem_rdata_valid = 1'b1;
    mem_rdata = 16'hBEEF;
    @(negedge sdram_clk);
    mem_rdata_valid = 1'b0;
    check("pre_reset_beat", burst_data, 32'h0000BEEF);
    check("pre_reset_busy", 32'(busy), 32'd1);
    nRESET = 1'b0;
    @(negedge sdram_clk);
    check("midrst_burst_data", burst_data, 32'h0);
    check("midrst_valid", 32'(burst_data_valid), 32'd0);
    check("midrst_done", 32'(burst_data_done), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_mem_rd", 32'(mem_rd), 32'd0);
    check("midrst_mem_addr", 32'(mem_addr), 32'd0);
    nRESET = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge sdram_clk);
      done_cnt += int'(burst_data_done) + int'(busy) + int'(burst_data_valid);
    end
    check("midrst_abandoned", 32'(done_cnt), 32'd0);
    run_burst(vecs[2], 1'b0);

    // Random bursts.
    for (int k = 0; k < 24; k++) begin
      rv.addr = 26'($urandom);
      if (k % 4 == 1) rv.addr = 26'h3FFFFE0 | 26'($urandom_range(31));
      rv.len = int'($urandom_range(20));
      rv.m32 = 1'($urandom);
      rv.rdy_pct = int'($urandom_range(100, 20));
      rv.lat_min = 1;
      rv.lat_max = int'($urandom_range(12, 1));
      rv.word_base = 0;
      rv.chk_first = 1'b0;
      rv.exp_addr0 = '0;
      rv.exp_beat0 = '0;
      rv.exp_beats = rv.m32 ? (rv.len + 1) / 2 : rv.len;
      run_burst(rv, k[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
